bus_txn_arbiter: RTL and testbench
==================================

# bus_txn_arbiter

Round-robin arbiter with bounded burst locking. It shares a single registered `bus_transaction_t` output stream between `NUM_REQ` requesters. It sits upstream of the transaction register/sub-module pipeline and decides which source feeds the datapath each cycle. A granted requester keeps ownership for up to `MAX_BURST` consecutive beats, then ownership rotates.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..16.
- `MAX_BURST`, default 4: maximum consecutive beats per grant, legal range 1..15.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `req_in` input, `bus_transaction_t [NUM_REQ]`: per-requester beat.
  - `.valid` is the request.
  - `.data`, `.addr` and `.ready` are payload.
- `req_accept` output, `NUM_REQ` bits: one-hot, combinational; bit i high means the beat from requester i transfers this cycle.
- `bus_out` output, `bus_transaction_t`: registered output beat. `.valid` qualifies the beat.
- `out_ready` input, 1 bit: downstream accepts `bus_out` this cycle.
- `grant_id` output, `$clog2(NUM_REQ)` bits: registered index of the source of the current `bus_out` beat.
- `busy` output, 1 bit: high when state is LOCKED or `bus_out.valid` is high.

## Operation
- `can_load` = `!bus_out.valid || out_ready`. The output register loads only when `can_load` is true.
- State IDLE:
  - If `can_load` and any `req_in[i].valid`, pick the first valid requester scanning from `last_winner+1` with wrap-around modulo `NUM_REQ`.
  - Assert `req_accept[winner]`, load the beat, set `last_winner = winner`, set `burst_cnt = 1`.
  - Go to LOCKED if `MAX_BURST > 1`; otherwise stay in IDLE.
- State LOCKED, owner = `last_winner`:
  - `can_load` and owner valid: accept, `burst_cnt++`. Return to IDLE when `burst_cnt` reaches `MAX_BURST`.
  - `can_load` and owner not valid: go to IDLE, no accept this cycle (exactly one bubble).
  - `!can_load`: hold state and counter. Other requesters' valids are ignored.
- Loaded beat:
  - `bus_out.data`, `.addr` and `.ready` are copied from the source.
  - `bus_out.valid` = 1.
  - `grant_id` = source index.
- Out of the loaded beat: on `out_ready` with no new load, `bus_out.valid` goes to 0. The payload fields hold their values.
- Counter width is `$clog2(MAX_BURST+1)`. The counter never exceeds `MAX_BURST`.
- Requesters that hold valid while not accepted must keep their payload stable.

## Timing
- Reset: synchronous, asserted at a rising edge. All of the following hold on the cycle after reset:
  - `bus_out` is all zero.
  - `grant_id` = 0 and `busy` = 0.
  - State is IDLE and `burst_cnt` = 0.
  - `last_winner` = `NUM_REQ-1`, so requester 0 wins first.
  - `req_accept` is forced to 0 while `rst` is high.
- Reset mid-burst aborts the burst. A beat offered in the reset cycle is not accepted.
- Accept-to-output latency: 1 cycle. `bus_out` shows an accepted beat on the edge after the `req_accept` cycle.
- Throughput: 1 beat per cycle.
  - No bubble on rotation at burst end: the LOCKED→IDLE transition and the next IDLE grant are back-to-back.
  - A bubble occurs only when the owner drops valid, or downstream stalls.
- Simultaneous `out_ready` and a new load: the old beat retires and the new beat is registered in the same edge.
- All requesters valid with `MAX_BURST` = 1: grants follow the order 0,1,2,3,0,…

## Structure
- Shared package `my_pkg`:
  - Reuse `bus_transaction_t`, `DATA_WIDTH`, `ADDR_WIDTH`.
  - Add `typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e`.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `NUM_REQ`-bit request vector, `last_winner`.
  - Outputs: one-hot grant, winner index, `any`.
- The arbiter instantiates one `rr_pick` and owns the FSM, the counter and the output register.

## Test plan
- Reset, then requester 2 only valid with `data` = 0x10 and `out_ready` = 1 → `req_accept` = 0b0100 on the same cycle; next cycle `bus_out` = {0x10, addr, valid=1} and `grant_id` = 2.
- All 4 requesters continuously valid, `MAX_BURST` = 4, `out_ready` = 1 → grant order 0×4, 1×4, 2×4, 3×4, 0…; 16 beats in 16 cycles, no bubbles.
- Owner 1 drops valid after 2 beats while requester 3 is valid → exactly one idle cycle, then requester 3 is granted.
- `out_ready` held 0 for 3 cycles mid-burst → `bus_out` is stable, `req_accept` = 0, `burst_cnt` is frozen; the burst resumes without losing or duplicating a beat.
- Downstream ready coincides with a new load → `bus_out` updates every cycle; scoreboard sees the data in order.
- `rst` asserted mid-burst → the following cycle has `bus_out` = 0 and state IDLE; requester 0 is granted first afterwards.

Source files
------------

// File: rtl/my_pkg.sv
// Shared bus types for the transaction pipeline and the arbiter FSM state encoding.
package my_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  ready;
        logic                  valid;
    } bus_transaction_t;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

endpackage

// File: rtl/bus_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last_winner+1.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_winner,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int SW  = IDW + 1;

    logic [SW-1:0]          start;
    logic [SW-1:0]          offset;
    logic [SW-1:0]          sum;
    logic [2*NUM_REQ-1:0]   req_dbl;
    logic [NUM_REQ-1:0]     req_rot;

    // Doubling the vector turns the wrap-around scan into a plain shift.
    assign start   = {1'b0, last_winner} + SW'(1);
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> start);

    // Descending scan so the lowest rotated offset wins.
    always_comb begin
        offset = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                offset = SW'(j);
            end
        end
    end

    assign sum    = start + offset;
    assign winner = (sum >= SW'(NUM_REQ)) ? IDW'(sum - SW'(NUM_REQ)) : IDW'(sum);
    assign any    = |req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = any && (winner == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/bus_txn_arbiter.sv
// Round-robin arbiter with bounded burst locking feeding one registered transaction stream.
module bus_txn_arbiter
    import my_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  bus_transaction_t           req_in [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_accept,
    output bus_transaction_t           bus_out,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    arb_state_e         state_reg, state_next;
    logic [CW-1:0]      burst_cnt_reg, burst_cnt_next;
    logic [IDW-1:0]     last_winner_reg, last_winner_next;
    bus_transaction_t   bus_out_reg;
    logic [IDW-1:0]     grant_id_reg;

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] owner_onehot;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDW-1:0]     pick_winner;
    logic               pick_any;
    logic               can_load;
    logic               owner_valid;
    logic [CW-1:0]      burst_cnt_inc;
    logic               load;
    logic [IDW-1:0]     load_idx;
    logic [NUM_REQ-1:0] accept_vec;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_valid[gi]    = req_in[gi].valid;
            assign owner_onehot[gi] = (last_winner_reg == IDW'(gi));
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req         (req_valid),
        .last_winner (last_winner_reg),
        .grant       (pick_grant),
        .winner      (pick_winner),
        .any         (pick_any)
    );

    assign can_load      = !bus_out_reg.valid || out_ready;
    assign owner_valid   = req_valid[last_winner_reg];
    assign burst_cnt_inc = burst_cnt_reg + CW'(1);

    always_comb begin
        state_next       = state_reg;
        burst_cnt_next   = burst_cnt_reg;
        last_winner_next = last_winner_reg;
        load             = 1'b0;
        load_idx         = last_winner_reg;
        accept_vec       = '0;
        case (state_reg)
            ARB_IDLE: begin
                if (can_load && pick_any) begin
                    load             = 1'b1;
                    load_idx         = pick_winner;
                    accept_vec       = pick_grant;
                    last_winner_next = pick_winner;
                    burst_cnt_next   = CW'(1);
                    state_next       = (MAX_BURST > 1) ? ARB_LOCKED : ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                // A stalled downstream freezes the burst; other requesters wait.
                if (can_load) begin
                    if (owner_valid) begin
                        load           = 1'b1;
                        accept_vec     = owner_onehot;
                        burst_cnt_next = burst_cnt_inc;
                        if (burst_cnt_inc == CW'(MAX_BURST)) begin
                            state_next = ARB_IDLE;
                        end
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ARB_IDLE;
            burst_cnt_reg   <= '0;
            last_winner_reg <= IDW'(NUM_REQ - 1);
            bus_out_reg     <= '0;
            grant_id_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            burst_cnt_reg   <= burst_cnt_next;
            last_winner_reg <= last_winner_next;
            if (load) begin
                bus_out_reg       <= req_in[load_idx];
                bus_out_reg.valid <= 1'b1;
                grant_id_reg      <= load_idx;
            end else if (out_ready) begin
                // Retire the beat but keep the payload visible.
                bus_out_reg.valid <= 1'b0;
            end
        end
    end

    assign req_accept = rst ? '0 : accept_vec;
    assign bus_out    = bus_out_reg;
    assign grant_id   = grant_id_reg;
    assign busy       = (state_reg == ARB_LOCKED) || bus_out_reg.valid;

endmodule

// File: tb/tb_bus_txn_arbiter.sv
// Bench for bus_txn_arbiter: directed and random steps against a behavioural reference model.
module tb_bus_txn_arbiter;
    import my_pkg::*;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int IW = $clog2(N);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             out_ready = 1'b0;
    bus_transaction_t req_in [N];
    logic [N-1:0]     acc0, acc1;
    bus_transaction_t out0, out1;
    logic [IW-1:0]    gid0, gid1;
    logic             busy0, busy1;

    typedef struct {
        int               owner;
        int               beats;
        int               last;
        int               gid;
        bus_transaction_t out;
    } mdl_t;

    mdl_t         m [2];
    int           burst_of [2] = '{MB, 1};
    int           exp_w [2];
    logic [N-1:0] seen_acc0;
    int           n_vec = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    bus_txn_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut0 (
        .clk(clk), .rst(rst), .req_in(req_in), .req_accept(acc0),
        .bus_out(out0), .out_ready(out_ready), .grant_id(gid0), .busy(busy0)
    );

    bus_txn_arbiter #(.NUM_REQ(N), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_in(req_in), .req_accept(acc1),
        .bus_out(out1), .out_ready(out_ready), .grant_id(gid1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    // Reference: one clock of the arbitration rules, using the inputs now on the pins.
    task automatic model_step(input int k);
        int  w;
        bit  can;
        w = -1;
        if (rst) begin
            m[k].owner = -1;
            m[k].beats = 0;
            m[k].last  = N - 1;
            m[k].gid   = 0;
            m[k].out   = '0;
            exp_w[k]   = -1;
            return;
        end
        can = !m[k].out.valid || out_ready;
        if (can) begin
            if (m[k].owner >= 0) begin
                if (req_in[m[k].owner].valid) begin
                    w = m[k].owner;
                    m[k].beats++;
                    if (m[k].beats == burst_of[k]) m[k].owner = -1;
                end else begin
                    m[k].owner = -1;
                end
            end else begin
                for (int d = 1; d <= N; d++) begin
                    if (w < 0 && req_in[(m[k].last + d) % N].valid) w = (m[k].last + d) % N;
                end
                if (w >= 0) begin
                    m[k].last  = w;
                    m[k].beats = 1;
                    m[k].owner = (burst_of[k] > 1) ? w : -1;
                end
            end
        end
        if (w >= 0) begin
            m[k].out = req_in[w];
            m[k].gid = w;
        end else if (out_ready) begin
            m[k].out.valid = 1'b0;
        end
        exp_w[k] = w;
    endtask

    task automatic tick();
        #2;
        model_step(0);
        model_step(1);
        seen_acc0 = acc0;
        chk("accept_mb4", 64'(acc0), 64'(onehot(exp_w[0])));
        chk("accept_mb1", 64'(acc1), 64'(onehot(exp_w[1])));
        @(posedge clk);
        #1;
        chk("bus_out_mb4", 64'(out0), 64'(m[0].out));
        chk("grant_id_mb4", 64'(gid0), 64'(m[0].gid));
        chk("busy_mb4", 64'(busy0), 64'(m[0].owner >= 0 || m[0].out.valid));
        chk("bus_out_mb1", 64'(out1), 64'(m[1].out));
        chk("grant_id_mb1", 64'(gid1), 64'(m[1].gid));
        chk("busy_mb1", 64'(busy1), 64'(m[1].owner >= 0 || m[1].out.valid));
        @(negedge clk);
    endtask

    task automatic new_beat(input int i, input logic v);
        req_in[i].valid = v;
        req_in[i].data  = DATA_WIDTH'($urandom);
        req_in[i].addr  = ADDR_WIDTH'($urandom);
        req_in[i].ready = 1'($urandom);
    endtask

    task automatic set_valids(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) new_beat(i, v[i]);
    endtask

    task automatic refresh_accepted();
        for (int i = 0; i < N; i++) begin
            if (exp_w[0] == i) new_beat(i, req_in[i].valid);
        end
    endtask

    initial begin
        set_valids('1);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("accept_in_reset", 64'(seen_acc0), 64'(0));
        tick();
        rst = 1'b0;

        // Single requester 2 with data 0x10.
        set_valids(4'b0100);
        req_in[2].data = 32'h10;
        tick();
        chk("tp1_accept", 64'(seen_acc0), 64'(4'b0100));
        chk("tp1_data", 64'(out0.data), 64'(32'h10));
        chk("tp1_valid", 64'(out0.valid), 64'(1));
        chk("tp1_grant_id", 64'(gid0), 64'(2));
        set_valids('0);
        tick();

        // All requesters valid: 0x4, 1x4, 2x4, 3x4 with no bubbles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_valids('1);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("rotation_order", 64'(seen_acc0), 64'(onehot(k / 4)));
            refresh_accepted();
        end

        // Downstream stall of 3 cycles in the middle of requester 0's burst.
        tick();
        refresh_accepted();
        tick();
        refresh_accepted();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_accept", 64'(seen_acc0), 64'(0));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("resume_owner", 64'(seen_acc0), 64'(4'b0001));
            refresh_accepted();
        end
        tick();
        chk("rotate_after_stall", 64'(seen_acc0), 64'(4'b0010));
        refresh_accepted();

        // Owner 1 drops after 2 beats while requester 3 waits.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_valids(4'b0010);
        tick();
        chk("drop_beat1", 64'(seen_acc0), 64'(4'b0010));
        refresh_accepted();
        tick();
        chk("drop_beat2", 64'(seen_acc0), 64'(4'b0010));
        set_valids(4'b1000);
        tick();
        chk("drop_bubble", 64'(seen_acc0), 64'(0));
        tick();
        chk("drop_next_owner", 64'(seen_acc0), 64'(4'b1000));

        // Random traffic: stable payload while waiting, random stalls and resets.
        for (int k = 0; k < 400; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            tick();
            for (int i = 0; i < N; i++) begin
                if (exp_w[0] == i || !req_in[i].valid) new_beat(i, $urandom_range(0, 2) != 0);
            end
        end

        // Reset in the middle of a burst.
        rst = 1'b0;
        out_ready = 1'b1;
        set_valids('1);
        tick();
        refresh_accepted();
        tick();
        refresh_accepted();
        rst = 1'b1;
        tick();
        chk("reset_accept", 64'(seen_acc0), 64'(0));
        chk("reset_bus_out", 64'(out0), 64'(0));
        chk("reset_busy", 64'(busy0), 64'(0));
        rst = 1'b0;
        tick();
        chk("post_reset_first", 64'(seen_acc0), 64'(4'b0001));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
